// File: rtl/bf16_drain_pkg.sv
// Shared types, constants and the round-robin pick helper for the bf16 drain arbiter.
package bf16_drain_pkg;

  typedef logic [31:0] f32_t;
  typedef logic [15:0] bf16_t;

  // Canonical quiet-NaN payload; the sign bit is prepended by the user.
  localparam logic [14:0] BF16_QNAN = 15'h7FC0;

  // rr_pick searches a fixed-width vector so it can live in the package;
  // callers zero-extend their valid vector and pass their real requester count.
  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 6;

  // Index of the first set bit of valid at or after ptr, wrapping at n.
  // Returns 0 when nothing is valid; callers gate the grant with |valid.
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX-1:0]   valid,
    input logic [RR_IDX_W-1:0] ptr,
    input logic [RR_IDX_W-1:0] n
  );
    logic [RR_IDX_W-1:0] idx;
    logic                found;
    // NOTE: inside functions and always_comb, blocking (=) assignments are
    // correct; each statement sees the value produced by the one before it.
    rr_pick = '0;
    found   = 1'b0;
    for (int i = 0; i < RR_MAX; i++) begin
      idx = ptr + RR_IDX_W'(i);
      if (idx >= n) idx = idx - n;
      if (RR_IDX_W'(i) < n && !found && valid[idx[RR_IDX_W-2:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/bf16_pack.sv
// Combinational float32 -> bfloat16 packer, round-to-nearest-even on the
// dropped low 16 bits. NaNs receive no special treatment here.
module bf16_pack
  import bf16_drain_pkg::*;
(
  input  f32_t  in_word,
  output bf16_t out_word
);

  logic round_up;

  // Round up above the halfway point, or exactly at it when the kept LSB is odd.
  always_comb begin
    round_up = (in_word[15:0] > 16'h8000) ||
               (in_word[15:0] == 16'h8000 && in_word[16]);
  end

  // Adding the carry to the upper half equals adding it at bit 16 of the full
  // word; the carry may ripple into the exponent (0x7F7FFFFF -> 0x7F80).
  assign out_word = in_word[31:16] + {15'd0, round_up};

endmodule

// File: rtl/bf16_drain_arb.sv
// Round-robin arbiter sharing one bf16 packer among N_REQ requesters, with a
// registered valid/ready output stage tagged by source ID.
// Optional feature: define BF16_DRAIN_NAN_FIX_EN to map every float32 NaN to a
// sign-preserving canonical bf16 quiet NaN instead of plain rounding.
module bf16_drain_arb
  import bf16_drain_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_REQ-1:0]  req_valid_i,
  input  logic [N_REQ*32-1:0] req_data_i,
  output logic [N_REQ-1:0]  req_ready_o,
  output logic              out_valid_o,
  output logic [15:0]       out_data_o,
  output logic [ID_W-1:0]   out_id_o,
  input  logic              out_ready_i,
  output logic [31:0]       xfer_cnt_o
);

  logic            load;
  logic            grant_any;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_id;
  f32_t            grant_word;
  bf16_t           packed_word;
  bf16_t           result;

  // The output register can take a word when empty or when draining this
  // cycle; reset suppresses any grant so nothing is consumed during it.
  assign load      = !rst_i && (!out_valid_o || out_ready_i);
  assign grant_any = load && (|req_valid_i);
  assign grant_id  = ID_W'(rr_pick(RR_MAX'(req_valid_i), RR_IDX_W'(rr_ptr),
                                   RR_IDX_W'(N_REQ)));

  // Select the granted requester's word and raise its one-hot ready bit.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant_word  = '0;
    req_ready_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_id == ID_W'(k)) grant_word = req_data_i[32*k +: 32];
    end
    if (grant_any) req_ready_o[grant_id] = 1'b1;
  end

  bf16_pack u_pack (
    .in_word  (grant_word),
    .out_word (packed_word)
  );

`ifdef BF16_DRAIN_NAN_FIX_EN
  // Exponent all ones with a non-zero mantissa is NaN: bypass rounding.
  assign result = (grant_word[30:23] == 8'hFF && (|grant_word[22:0]))
                ? {grant_word[31], BF16_QNAN} : packed_word;
`else
  assign result = packed_word;
`endif

  // Output stage, round-robin pointer and handshake counter.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of statement order.
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_id_o    <= '0;
      rr_ptr      <= '0;
      xfer_cnt_o  <= '0;
    end else begin
      if (out_valid_o && out_ready_i) xfer_cnt_o <= xfer_cnt_o + 32'd1;
      if (grant_any) begin
        out_valid_o <= 1'b1;
        out_data_o  <= result;
        out_id_o    <= grant_id;
        rr_ptr      <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end else if (load) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bf16_drain_arb.sv
// Directed self-checking bench for bf16_drain_arb (N_REQ = 4).
module tb_bf16_drain_arb;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [15:0]  out_data;
  logic [1:0]   out_id;
  logic         out_ready;
  logic [31:0]  xfer_cnt;

  int pass_cnt  = 0;
  int check_cnt = 0;

  bf16_drain_arb #(.N_REQ(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_id_o    (out_id),
    .out_ready_i (out_ready),
    .xfer_cnt_o  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'hF; req_data = '1; out_ready = 1'b1;
    step(); step();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else pass_cnt++;
    check_cnt++; if (out_data !== 16'h0000) $display("FAIL rst_data: got %h want 0000", out_data); else pass_cnt++;
    check_cnt++; if (out_id !== 2'd0) $display("FAIL rst_id: got %0d want 0", out_id); else pass_cnt++;
    check_cnt++; if (xfer_cnt !== 32'd0) $display("FAIL rst_cnt: got %h want 0", xfer_cnt); else pass_cnt++;
    check_cnt++; if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", req_ready); else pass_cnt++;
    rst = 1'b0; req_valid = 4'h0; req_data = '0;
  endtask

  task automatic test_rounding();
    logic [31:0] vin [3];
    logic [15:0] vexp [3];
    vin[0] = 32'h3F81_8000; vexp[0] = 16'h3F82;
    vin[1] = 32'h3F80_8000; vexp[1] = 16'h3F80;
    vin[2] = 32'h3F80_8001; vexp[2] = 16'h3F81;
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0001; req_data[31:0] = vin[i];
      #1;
      check_cnt++; if (req_ready !== 4'b0001) $display("FAIL rnd_ready[%0d]: got %b want 0001", i, req_ready); else pass_cnt++;
      step();
      check_cnt++; if (out_valid !== 1'b1 || out_data !== vexp[i] || out_id !== 2'd0)
        $display("FAIL rnd_out[%0d]: got v=%b d=%h id=%0d want v=1 d=%h id=0", i, out_valid, out_data, out_id, vexp[i]);
      else pass_cnt++;
    end
    req_valid = 4'b0000;
    step();
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL rnd_drain: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) req_data[32*k +: 32] = 32'h3F80_0000 + (k << 16);
    for (int i = 0; i < 5; i++) begin
      int e;
      e = i % 4;
      #1;
      check_cnt++; if (req_ready !== 4'(1 << e)) $display("FAIL rr_ready[%0d]: got %b want %b", i, req_ready, 4'(1 << e)); else pass_cnt++;
      step();
      check_cnt++; if (out_id !== 2'(e) || out_data !== 16'(16'h3F80 + e))
        $display("FAIL rr_out[%0d]: got id=%0d d=%h want id=%0d d=%h", i, out_id, out_data, e, 16'(16'h3F80 + e));
      else pass_cnt++;
    end
    req_valid = 4'b0000;
    step();
    check_cnt++; if (xfer_cnt !== 32'd5) $display("FAIL rr_cnt: got %0d want 5", xfer_cnt); else pass_cnt++;
    check_cnt++; if (out_valid !== 1'b0) $display("FAIL rr_empty: got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    req_valid = 4'b0100; req_data[95:64] = 32'h4049_0FDB;
    #1;
    check_cnt++; if (req_ready !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", req_ready); else pass_cnt++;
    step();
    req_data[95:64] = 32'h3F80_0000;
    for (int i = 0; i < 3; i++) begin
      check_cnt++; if (req_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b want 0000", i, req_ready); else pass_cnt++;
      check_cnt++; if (out_valid !== 1'b1 || out_data !== 16'h4049 || out_id !== 2'd2 || xfer_cnt !== 32'd5)
        $display("FAIL bp_hold[%0d]: got v=%b d=%h id=%0d cnt=%0d want v=1 d=4049 id=2 cnt=5", i, out_valid, out_data, out_id, xfer_cnt);
      else pass_cnt++;
      step();
    end
    out_ready = 1'b1;
    #1;
    check_cnt++; if (req_ready !== 4'b0100) $display("FAIL bp_release: got %b want 0100", req_ready); else pass_cnt++;
    step();
    check_cnt++; if (out_data !== 16'h3F80 || out_id !== 2'd2 || xfer_cnt !== 32'd6)
      $display("FAIL bp_next: got d=%h id=%0d cnt=%0d want d=3F80 id=2 cnt=6", out_data, out_id, xfer_cnt);
    else pass_cnt++;
    req_valid = 4'b0000;
    step();
    check_cnt++; if (xfer_cnt !== 32'd7 || out_valid !== 1'b0)
      $display("FAIL bp_drain: got cnt=%0d v=%b want cnt=7 v=0", xfer_cnt, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_special();
    logic [31:0] vin [4];
    logic [15:0] vexp [4];
    vin[0] = 32'h7F80_0001;
    vin[1] = 32'h7F7F_FFFF; vexp[1] = 16'h7F80;
    vin[2] = 32'h7FFF_FFFF;
    vin[3] = 32'hFF80_0001;
`ifdef BF16_DRAIN_NAN_FIX_EN
    vexp[0] = 16'h7FC0; vexp[2] = 16'h7FC0; vexp[3] = 16'hFFC0;
`else
    vexp[0] = 16'h7F80; vexp[2] = 16'h8000; vexp[3] = 16'hFF80;
`endif
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'b0010; req_data[63:32] = vin[i];
      step();
      check_cnt++; if (out_valid !== 1'b1 || out_data !== vexp[i] || out_id !== 2'd1)
        $display("FAIL special[%0d] in=%h: got v=%b d=%h id=%0d want v=1 d=%h id=1", i, vin[i], out_valid, out_data, out_id, vexp[i]);
      else pass_cnt++;
    end
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    req_valid = 4'b1010;
    req_data[63:32]   = 32'h3F80_0000;
    req_data[127:96]  = 32'h4000_0000;
    #1;
    check_cnt++; if (req_ready !== 4'b1000) $display("FAIL mid_grant: got %b want 1000", req_ready); else pass_cnt++;
    step();
    check_cnt++; if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 16'h4000)
      $display("FAIL mid_full: got v=%b id=%0d d=%h want v=1 id=3 d=4000", out_valid, out_id, out_data);
    else pass_cnt++;
    rst = 1'b1; out_ready = 1'b1;
    #1;
    check_cnt++; if (req_ready !== 4'b0000) $display("FAIL mid_rst_ready: got %b want 0000", req_ready); else pass_cnt++;
    step();
    check_cnt++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_id !== 2'd0 || xfer_cnt !== 32'd0)
      $display("FAIL mid_rst_state: got v=%b d=%h id=%0d cnt=%0d want all zero", out_valid, out_data, out_id, xfer_cnt);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    check_cnt++; if (req_ready !== 4'b0010) $display("FAIL mid_first_grant: got %b want 0010", req_ready); else pass_cnt++;
    step();
    check_cnt++; if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== 16'h3F80)
      $display("FAIL mid_first_out: got v=%b id=%0d d=%h want v=1 id=1 d=3F80", out_valid, out_id, out_data);
    else pass_cnt++;
    req_valid = 4'b0000;
    step();
  endtask

  task automatic test_wrap();
    force dut.xfer_cnt_o = 32'hFFFF_FFFE;
    #1;
    release dut.xfer_cnt_o;
    req_valid = 4'b0001; req_data[31:0] = 32'h3F80_0000;
    step();
    req_valid = 4'b0000;
    step();
    check_cnt++; if (xfer_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_max: got %h want FFFFFFFF", xfer_cnt); else pass_cnt++;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0000;
    step();
    check_cnt++; if (xfer_cnt !== 32'h0000_0000) $display("FAIL wrap_zero: got %h want 00000000", xfer_cnt); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    test_reset();
    test_rounding();
    test_round_robin();
    test_backpressure();
    test_special();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/bf16_drain_arb.md
# bf16_drain_arb

Round-robin arbiter and output sequencer that shares one float32→bfloat16 round-to-nearest-even packer among `N_REQ` requesters. It sits between the systolic array's column accumulators and the result write-back path. Each cycle it grants at most one valid requester, rounds that requester's float32 word to bf16, and holds the result in a registered valid/ready output stage tagged with the source ID.

## Interface
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `ID_W`, default `$clog2(N_REQ)`: derived width of the ID field; not to be overridden.
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `req_valid_i`  in  `N_REQ`  per-requester valid.
- `req_data_i`  in  `N_REQ*32`  per-requester IEEE-754 float32 word; requester k occupies bits `[32k+31:32k]`.
- `req_ready_o`  out  `N_REQ`  one-hot grant/accept; at most one bit set.
- `out_valid_o`  out  1  output register holds a result.
- `out_data_o`  out  16  bf16 result.
- `out_id_o`  out  `ID_W`  index of the requester that produced `out_data_o`.
- `out_ready_i`  in  1  downstream accept.
- `xfer_cnt_o`  out  32  count of completed output handshakes; wraps from 0xFFFF_FFFF to 0.

## Operation
- Output stage has two implicit states:
  - EMPTY: `out_valid_o` = 0.
  - FULL: `out_valid_o` = 1.
- Accept condition: `load = !out_valid_o || out_ready_i`. A new word may enter in the same cycle the old one drains.
- When `load` is true and any `req_valid_i` bit is set:
  - Grant the first valid requester at or after `rr_ptr`, searching with wrap-around.
  - Assert that requester's `req_ready_o` bit (combinational from `req_valid_i`, `rr_ptr` and `load`).
  - On the next edge, register the rounded bf16 value and the grant ID, and set `out_valid_o`.
  - On the same edge, set `rr_ptr` to the granted index + 1, wrapping to 0 after `N_REQ-1`.
- When `load` is true and no requester is valid:
  - `out_valid_o` clears if the held word drained.
  - `rr_ptr` is unchanged.
- When `load` is false, `req_ready_o` is all zeros.
- Output stability: `out_data_o` and `out_id_o` stay stable while `out_valid_o && !out_ready_i`.
- Requester handshake: a requester holds `req_valid_i` and its data until it sees `req_ready_o`. Valid may drop without a grant (no protocol error; that requester is simply skipped).
- Rounding, round-to-nearest-even on the dropped low 16 bits:
  - Round up if `low16 > 0x8000`.
  - Round up if `low16 == 0x8000` and bit 16 = 1.
  - Add the carry at bit 16 in 32-bit arithmetic and take bits `[31:16]`. The carry may propagate into the exponent; 0x7F7FFFFF rounds to 0x7F80 (inf).
- `xfer_cnt_o` increments on every cycle with `out_valid_o && out_ready_i`.
- Reset values: `out_valid_o` = 0, `out_data_o` = 0x0000, `out_id_o` = 0, `rr_ptr` = 0, `xfer_cnt_o` = 0, `req_ready_o` = 0.
- Reset mid-operation: the held result is discarded without a handshake, and no grant is issued in the reset cycle.

## Timing
- Latency from grant to `out_valid_o` is 1 cycle.
- Throughput is 1 result per cycle when `out_ready_i` is held high.
- There are no combinational paths from `req_data_i` to outputs. `req_ready_o` depends combinationally on `out_ready_i`.
- Fairness: any requester holding valid is granted within `N_REQ` accept cycles.

## Configuration
- Macro: `BF16_DRAIN_NAN_FIX_EN`.
- Defined: an input with exponent 0xFF and non-zero mantissa outputs `{sign, 15'h7FC0}`, the canonical quiet NaN with the sign preserved. This bypasses rounding, so 0x7FFFFFFF gives 0x7FC0 and 0x7F800001 gives 0x7FC0.
- Undefined: NaNs go through plain rounding. 0x7F800001 gives 0x7F80 (inf), and 0x7FFFFFFF gives 0x8000. This matches the golden float model used by existing benches.

## Structure
- Package `bf16_drain_pkg` holds:
  - typedef `f32_t` (logic [31:0]);
  - typedef `bf16_t` (logic [15:0]);
  - constant `BF16_QNAN` = 15'h7FC0;
  - function `rr_pick(valid, ptr)` returning the grant index.
- Sub-module: the existing combinational `bf16_pack` rounding unit, instantiated once on the muxed granted word. The NaN fix is applied outside the sub-module.

## Test plan
- Single requester 0 sends 0x3F818000 → `out_data_o` = 0x3F82, `out_id_o` = 0, one cycle after the grant. Then 0x3F808000 → 0x3F80, and 0x3F808001 → 0x3F81.
- All 4 requesters hold valid, with `out_ready_i` = 1 → grant order 0,1,2,3,0 in back-to-back cycles, and `xfer_cnt_o` = 5 after 5 transfers.
- `out_ready_i` low for 3 cycles while holding 0x4049 from requester 2 → `out_data_o`/`out_id_o` stable, `req_ready_o` = 0, and no extra count.
- Input 0x7F800001:
  - with `BF16_DRAIN_NAN_FIX_EN` → 0x7FC0;
  - without it → 0x7F80.
  - Input 0x7F7FFFFF → 0x7F80 in both builds.
- Assert `rst_i` while `out_valid_o` = 1 and requesters are valid → next cycle all outputs are at reset values. After release, the first grant goes to the lowest valid index from `rr_ptr` = 0.
- `xfer_cnt_o` forced near wrap (run 2^32 transfers, or preload via force) → 0xFFFF_FFFF then 0x0000_0000.
